// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared types, button indices and timing helper for the pad scanner
package nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_SNES_A = 8;
  localparam int BTN_SNES_X = 9;
  localparam int BTN_SNES_L = 10;
  localparam int BTN_SNES_R = 11;

  // Busy cycles of one frame: latch, NUM_BITS+1 low phases, NUM_BITS high phases, commit.
  function automatic int frame_cycles(input int num_bits, input int half_period);
    return 2 * half_period + (num_bits + 1) * half_period + num_bits * half_period + 1;
  endfunction

endpackage

// File: rtl/nes_pad_channel.sv
// rtl/nes_pad_channel.sv - one pad's deserialiser, presence flag, held buttons and edge strobes
module nes_pad_channel
  import nes_pkg::*;
#(
  parameter int NUM_BITS = 8,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_data,
  input  logic                i_sample_en,
  input  logic [IDX_W-1:0]    i_bit_idx,
  input  logic                i_commit,
  output logic [NUM_BITS-1:0] o_buttons,
  output logic                o_connected,
  output logic [NUM_BITS-1:0] o_pressed,
  output logic [NUM_BITS-1:0] o_released
);

  logic [NUM_BITS-1:0] r_shift;
  logic                r_presence;
  logic [NUM_BITS-1:0] r_buttons;
  logic                r_connected;
  logic [NUM_BITS-1:0] r_pressed;
  logic [NUM_BITS-1:0] r_released;
  logic [NUM_BITS-1:0] w_new;

  // A pad that did not answer the presence bit reports nothing pressed.
  assign w_new = r_presence ? r_shift : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_presence <= 1'b0;
    end else if (i_sample_en) begin
      if (i_bit_idx == IDX_W'(NUM_BITS)) begin
        r_presence <= ~i_data;
      end
      for (int b = 0; b < NUM_BITS; b++) begin
        if (i_bit_idx == IDX_W'(b)) begin
          r_shift[b] <= ~i_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buttons   <= '0;
      r_connected <= 1'b0;
      r_pressed   <= '0;
      r_released  <= '0;
    end else begin
      r_pressed  <= '0;
      r_released <= '0;
      if (i_commit) begin
        r_buttons   <= w_new;
        r_connected <= r_presence;
        r_pressed   <= w_new & ~r_buttons;
        r_released  <= ~w_new & r_buttons;
      end
    end
  end

  assign o_buttons   = r_buttons;
  assign o_connected = r_connected;
  assign o_pressed   = r_pressed;
  assign o_released  = r_released;

endmodule

// File: rtl/nes_pad_scanner.sv
// rtl/nes_pad_scanner.sv - lock-step NES/SNES pad poller: poll timer, pad FSM and per-pad channels
module nes_pad_scanner
  import nes_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int NUM_BITS    = 8,
  parameter int HALF_PERIOD = 150,
  parameter int POLL_CYCLES = 416667
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_PADS-1:0]          pad_data,
  output logic [NUM_PADS-1:0]          pad_clk,
  output logic [NUM_PADS-1:0]          pad_latch,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic [NUM_PADS-1:0]          connected,
  output logic [NUM_PADS*NUM_BITS-1:0] pressed,
  output logic [NUM_PADS*NUM_BITS-1:0] released,
  output logic                         frame_valid,
  output logic                         busy
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW = $clog2(2 * HALF_PERIOD + 1);
  localparam int BW = $clog2(NUM_BITS + 1);
  localparam logic [TW-1:0] LATCH_LAST = TW'(2 * HALF_PERIOD - 1);
  localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_PERIOD - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [PW-1:0] r_poll;
  logic          w_tick;
  logic [TW-1:0] r_timer;
  logic          w_timer_done;
  logic [BW-1:0] r_bit;
  logic          w_last_bit;
  logic          w_sample_en;
  logic          w_commit;
  logic          r_pad_latch;
  logic          r_pad_clk;
  logic          r_busy;
  logic          r_frame_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_poll <= '0;
    end else if (r_poll == PW'(POLL_CYCLES - 1)) begin
      r_poll <= '0;
    end else begin
      r_poll <= r_poll + PW'(1);
    end
  end

  assign w_tick       = (r_poll == '0);
  assign w_timer_done = (r_timer == '0);
  assign w_last_bit   = (r_bit == BW'(NUM_BITS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Ticks outside IDLE are simply ignored, so an overlong frame never gets cut short.
  always_comb begin
    w_next_state = r_state;
    w_sample_en  = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick && enable) begin
          w_next_state = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (w_timer_done) begin
          w_next_state = ST_LOW;
        end
      end
      ST_LOW: begin
        if (w_timer_done) begin
          w_sample_en  = 1'b1;
          w_next_state = w_last_bit ? ST_DONE : ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (w_timer_done) begin
          w_next_state = ST_LOW;
        end
      end
      ST_DONE: begin
        w_commit     = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Pad lines are decoded from the next state so they are glitch-free and aligned with r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer       <= '0;
      r_bit         <= '0;
      r_pad_latch   <= 1'b0;
      r_pad_clk     <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_valid <= 1'b0;
    end else begin
      if (w_next_state != r_state) begin
        r_timer <= (w_next_state == ST_LATCH) ? LATCH_LAST : HALF_LAST;
      end else if (!w_timer_done) begin
        r_timer <= r_timer - TW'(1);
      end
      if (r_state == ST_LATCH) begin
        r_bit <= '0;
      end else if (r_state == ST_HIGH && w_timer_done) begin
        r_bit <= r_bit + BW'(1);
      end
      r_pad_latch   <= (w_next_state == ST_LATCH);
      r_pad_clk     <= (w_next_state == ST_HIGH);
      r_busy        <= (w_next_state != ST_IDLE);
      r_frame_valid <= w_commit;
    end
  end

  assign pad_latch   = {NUM_PADS{r_pad_latch}};
  assign pad_clk     = {NUM_PADS{r_pad_clk}};
  assign busy        = r_busy;
  assign frame_valid = r_frame_valid;

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    nes_pad_channel #(
      .NUM_BITS (NUM_BITS),
      .IDX_W    (BW)
    ) u_channel (
      .clk         (clk),
      .reset       (reset),
      .i_data      (pad_data[p]),
      .i_sample_en (w_sample_en),
      .i_bit_idx   (r_bit),
      .i_commit    (w_commit),
      .o_buttons   (buttons[p*NUM_BITS +: NUM_BITS]),
      .o_connected (connected[p]),
      .o_pressed   (pressed[p*NUM_BITS +: NUM_BITS]),
      .o_released  (released[p*NUM_BITS +: NUM_BITS])
    );
  end

endmodule
